// File: rtl/ps2_scancode_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx_if
// Groups the PS/2 line inputs and the scancode delivery outputs of
// ps2_scancode_rx into one bundle.
//   master : used by the receiver (takes the PS/2 lines, drives the results)
//   slave  : used by the keyboard side / consumer (drives the PS/2 lines,
//            observes the results)
// Signals:
//   ps2_clk, ps2_data         PS/2 lines from the keyboard (asynchronous)
//   scancode[7:0]             last delivered make code, held between deliveries
//   valid                     1-cycle pulse, scancode/extended updated
//   extended                  delivered code was preceded by E0
//   parity_err                1-cycle pulse, frame dropped on odd-parity failure
//   frame_err                 1-cycle pulse, bad stop bit or timeout abort
// -----------------------------------------------------------------------------
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       valid;
    logic       extended;
    logic       parity_err;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output scancode,
        output valid,
        output extended,
        output parity_err,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  scancode,
        input  valid,
        input  extended,
        input  parity_err,
        input  frame_err
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// ps2_scancode_rx
// Receives 11-bit PS/2 keyboard frames (start, 8 data LSB-first, odd parity,
// stop) and delivers make codes to the downstream keyboard decoder.
// Break sequences (F0 xx) are stripped, E0-prefixed codes are flagged as
// extended. Bad frames are dropped and reported with a one-cycle error pulse.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    ps2_scancode_rx_if.master: ps2_clk/ps2_data in;
//          scancode/valid/extended/parity_err/frame_err out
// Parameters:
//   FILTER_LEN      consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYCLES  idle cycles inside a frame before it is aborted
//   SUPPRESS_BREAK  1: drop the byte after F0; 0: deliver it
// -----------------------------------------------------------------------------
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit SUPPRESS_BREAK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    ps2_scancode_rx_if.master bus
);

    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    BRK   = 8'hF0;
    localparam logic [7:0]    EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Two-flop synchronisers for both asynchronous PS/2 lines.
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;

    // Sample histories. The clock history feeds the glitch filter; the data
    // history has the same depth so the data bit read on a filtered falling
    // edge is the one that was on the line when ps2_clk actually fell.
    logic [FILTER_LEN-1:0] clk_hist_q;
    logic [FILTER_LEN-1:0] data_hist_q;

    logic filt_q, filt_d;
    logic fe;
    logic data_s;

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          break_pend_q, break_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          extended_q, extended_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_hist_q  <= '1;
            data_hist_q <= '1;
            filt_q      <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk};
            data_sync_q <= {data_sync_q[0], bus.ps2_data};
            clk_hist_q  <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
            data_hist_q <= {data_hist_q[FILTER_LEN-2:0], data_sync_q[1]};
            filt_q      <= filt_d;
        end
    end

    // Filtered clock only moves when the whole history agrees.
    always_comb begin
        filt_d = filt_q;
        if (&clk_hist_q) begin
            filt_d = 1'b1;
        end else if (~|clk_hist_q) begin
            filt_d = 1'b0;
        end
    end

    // Falling edge is flagged in the cycle the filtered clock is about to drop,
    // so the FSM acts on the same edge that updates filt_q.
    assign fe     = filt_q & ~filt_d;
    assign data_s = data_hist_q[FILTER_LEN-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            tcnt_q       <= '0;
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            scancode_q   <= '0;
            extended_q   <= 1'b0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            tcnt_q       <= tcnt_d;
            break_pend_q <= break_pend_d;
            ext_pend_q   <= ext_pend_d;
            scancode_q   <= scancode_d;
            extended_q   <= extended_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        tcnt_d       = (state_q == S_IDLE) ? '0 : tcnt_q + TW'(1);
        break_pend_d = break_pend_q;
        ext_pend_d   = ext_pend_q;
        scancode_d   = scancode_q;
        extended_d   = extended_q;
        valid_d      = 1'b0;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;

        // Timeout wins over a falling edge landing in the same cycle.
        if (state_q != S_IDLE && tcnt_q == TLAST) begin
            state_d = S_IDLE;
            tcnt_d  = '0;
            ferr_d  = 1'b1;
        end else if (fe) begin
            tcnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!data_s) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    shreg_d  = {data_s, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_d = data_s;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    // Stop bit is judged first so a frame raises one error only.
                    if (!data_s) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shreg_q, parity_q})) begin
                        perr_d = 1'b1;
                    end else if (shreg_q == BRK) begin
                        break_pend_d = 1'b1;
                    end else if (shreg_q == EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (break_pend_q) begin
                        break_pend_d = 1'b0;
                        ext_pend_d   = 1'b0;
                        if (!SUPPRESS_BREAK) begin
                            scancode_d = shreg_q;
                            extended_d = ext_pend_q;
                            valid_d    = 1'b1;
                        end
                    end else begin
                        scancode_d = shreg_q;
                        extended_d = ext_pend_q;
                        valid_d    = 1'b1;
                        ext_pend_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.scancode   = scancode_q;
    assign bus.extended   = extended_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_scancode_rx
// Drives PS/2 frames into two receivers (break suppression on and off) and
// compares their pulses and held outputs with a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 5000;
    localparam int HALF       = 20;   // PS/2 half period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2_clk_drv = 1'b1;
    logic ps2_data_drv = 1'b1;

    always #10 clk = ~clk;

    ps2_scancode_rx_if bus0 ();
    ps2_scancode_rx_if bus1 ();

    assign bus0.ps2_clk  = ps2_clk_drv;
    assign bus0.ps2_data = ps2_data_drv;
    assign bus1.ps2_clk  = ps2_clk_drv;
    assign bus1.ps2_data = ps2_data_drv;

    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT), .SUPPRESS_BREAK(1'b1))
        u_dut_sb (.clk(clk), .reset(reset), .bus(bus0));
    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT), .SUPPRESS_BREAK(1'b0))
        u_dut_nsb (.clk(clk), .reset(reset), .bus(bus1));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- observation ----------------
    int         cyc = 0;
    int         stop_fall_cyc = 0;
    int         n_valid [2];
    int         n_perr  [2];
    int         n_ferr  [2];
    logic [7:0] cap_sc  [2];
    logic       cap_ext [2];
    logic [7:0] cur_sc  [2];
    logic       cur_ext [2];
    logic       cur_v   [2];
    logic       cur_pe  [2];
    logic       cur_fe  [2];
    bit         prev_pulse [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int k, input logic v, input logic pe, input logic fe,
                       input logic [7:0] sc, input logic ex);
        int np;
        cur_sc[k]  = sc;
        cur_ext[k] = ex;
        cur_v[k]   = v;
        cur_pe[k]  = pe;
        cur_fe[k]  = fe;
        if (reset) begin
            prev_pulse[k] = 1'b0;
        end else begin
            np = int'(v) + int'(pe) + int'(fe);
            if (np != 0) begin
                check_eq("pulse_excl", np, 1);
                check_eq("pulse_b2b", prev_pulse[k], 0);
            end
            if (v) begin
                n_valid[k]++;
                cap_sc[k]  = sc;
                cap_ext[k] = ex;
                check_eq("valid_latency",
                         ((cyc - stop_fall_cyc) >= FILTER_LEN + 2 &&
                          (cyc - stop_fall_cyc) <= FILTER_LEN + 4), 1);
            end
            if (pe) n_perr[k]++;
            if (fe) n_ferr[k]++;
            prev_pulse[k] = (np != 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.valid, bus0.parity_err, bus0.frame_err, bus0.scancode, bus0.extended);
        mon(1, bus1.valid, bus1.parity_err, bus1.frame_err, bus1.scancode, bus1.extended);
    end

    // ---------------- reference model ----------------
    bit         m_brk [2];
    bit         m_ext [2];
    logic [7:0] m_sc  [2];
    bit         m_xo  [2];
    int         exp_v [2];
    int         exp_p [2];
    int         exp_f [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_brk[k] = 0; m_ext[k] = 0; m_sc[k] = 8'h00; m_xo[k] = 0;
        end
    endtask

    task automatic exp_none();
        for (int k = 0; k < 2; k++) begin
            exp_v[k] = 0; exp_p[k] = 0; exp_f[k] = 0;
        end
    endtask

    // Byte-level rules: what a complete frame means for each receiver.
    task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        bit sb;
        bit ext_was;
        exp_none();
        for (int k = 0; k < 2; k++) begin
            sb = (k == 0);
            if (!stop_ok) exp_f[k] = 1;
            else if (!par_ok) exp_p[k] = 1;
            else if (b == 8'hF0) m_brk[k] = 1;
            else if (b == 8'hE0) m_ext[k] = 1;
            else begin
                ext_was = m_ext[k];
                m_ext[k] = 0;
                if (m_brk[k]) begin
                    m_brk[k] = 0;
                    if (!sb) begin
                        exp_v[k] = 1; m_sc[k] = b; m_xo[k] = ext_was;
                    end
                end else begin
                    exp_v[k] = 1; m_sc[k] = b; m_xo[k] = ext_was;
                end
            end
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            n_valid[k] = 0; n_perr[k] = 0; n_ferr[k] = 0;
        end
    endtask

    task automatic check_obs(input string tag);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq({tag, "_valid_cnt"}, n_valid[k], exp_v[k]);
            check_eq({tag, "_perr_cnt"}, n_perr[k], exp_p[k]);
            check_eq({tag, "_ferr_cnt"}, n_ferr[k], exp_f[k]);
            if (exp_v[k] != 0 && n_valid[k] != 0) begin
                check_eq({tag, "_sc_at_valid"}, cap_sc[k], m_sc[k]);
                check_eq({tag, "_ext_at_valid"}, cap_ext[k], m_xo[k]);
            end
            check_eq({tag, "_sc_hold"}, cur_sc[k], m_sc[k]);
            check_eq({tag, "_ext_hold"}, cur_ext[k], m_xo[k]);
        end
        clear_obs();
    endtask

    // ---------------- stimulus ----------------
    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF / 2) @(negedge clk);
            ps2_data_drv = fr[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk_drv = 1'b0;
            stop_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk_drv = 1'b1;
        end
        repeat (HALF / 2) @(negedge clk);
        ps2_data_drv = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        p = par_ok ? ~(^b) : (^b);
        send_bits({stop_ok ? 1'b1 : 1'b0, p, b, 1'b0}, 11);
        repeat (30) @(negedge clk);
        model_frame(b, par_ok, stop_ok);
        check_obs(tag);
    endtask

    task automatic glitch(input int len);
        @(negedge clk);
        ps2_data_drv = 1'b0;
        ps2_clk_drv  = 1'b0;
        repeat (len) @(negedge clk);
        ps2_clk_drv  = 1'b1;
        repeat (4) @(negedge clk);
        ps2_data_drv = 1'b1;
        repeat (40) @(negedge clk);
        exp_none();
        check_obs("glitch");
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        bit         pok;
        bit         sok;

        clear_obs();
        model_reset();
        for (int k = 0; k < 2; k++) prev_pulse[k] = 0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_scancode", cur_sc[k], 8'h00);
            check_eq("rst_valid", cur_v[k], 0);
            check_eq("rst_extended", cur_ext[k], 0);
            check_eq("rst_parity_err", cur_pe[k], 0);
            check_eq("rst_frame_err", cur_fe[k], 0);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);

        run_frame("f2b", 8'h2B, 1, 1);
        run_frame("brk_f0", 8'hF0, 1, 1);
        run_frame("brk_2b", 8'h2B, 1, 1);
        run_frame("brk_15", 8'h15, 1, 1);
        run_frame("ext_e0", 8'hE0, 1, 1);
        run_frame("ext_75", 8'h75, 1, 1);
        run_frame("ext_75b", 8'h75, 1, 1);
        run_frame("par_1d", 8'h1D, 0, 1);
        run_frame("stop_5a", 8'h5A, 1, 0);

        // Partial frame: start plus four data bits, then silence.
        send_bits({3'b111, 8'h33, 1'b0}, 5);
        repeat (TIMEOUT - 300) @(negedge clk);
        exp_none();
        check_obs("to_early");
        repeat (400) @(negedge clk);
        exp_none();
        exp_f[0] = 1;
        exp_f[1] = 1;
        check_obs("to_abort");
        run_frame("to_33", 8'h33, 1, 1);

        glitch(3);
        glitch(FILTER_LEN - 1);
        run_frame("post_glitch", 8'h4C, 1, 1);

        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20) b = 8'hF0;
            else if (r < 35) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            pok = ($urandom_range(0, 9) != 0);
            sok = ($urandom_range(0, 9) != 0);
            run_frame("rand", b, pok, sok);
        end
        run_frame("pre_rst", 8'h1C, 1, 1);

        // Reset in the middle of a frame.
        send_bits({3'b111, 8'h66, 1'b0}, 5);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_eq("midrst_scancode", cur_sc[k], 8'h00);
            check_eq("midrst_valid", cur_v[k], 0);
            check_eq("midrst_extended", cur_ext[k], 0);
            check_eq("midrst_parity_err", cur_pe[k], 0);
            check_eq("midrst_frame_err", cur_fe[k], 0);
        end
        reset = 1'b0;
        model_reset();
        clear_obs();
        repeat (20) @(negedge clk);
        run_frame("post_rst_22", 8'h22, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
